riscv_pmp_arb: RTL and testbench

- Shares one Physical Memory Protection checker instance between the instruction-fetch and data-access requesters of the core.
- Arbitrates requests, registers the winning access into a check stage that drives the checker's request inputs, and returns a registered per-requester result (valid plus exception).
- Sits between the instruction/data memory front-ends and the PMP checker.
- Fully pipelined: one check accepted per cycle.

---
 rtl/biu_constants_pkg.sv | 16 +
 rtl/riscv_state_pkg.sv | 15 +
 rtl/riscv_pmp_arb_sel.sv | 71 +++++++
 rtl/riscv_pmp_arb.sv | 149 ++++++++++++++
 tb/tb_riscv_pmp_arb.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/biu_constants_pkg.sv
// ---------------------------------------------------------------------------
// biu_constants_pkg
// Bus interface unit constants shared by the memory front-ends and the PMP
// checker. Provides the transfer-size encoding biu_size_t.
// ---------------------------------------------------------------------------
package biu_constants_pkg;

   typedef enum logic [2:0] {
      BYTE  = 3'b000,
      HWORD = 3'b001,
      WORD  = 3'b010,
      DWORD = 3'b011,
      QWORD = 3'b100
   } biu_size_t;

endpackage

// File: rtl/riscv_state_pkg.sv
// ---------------------------------------------------------------------------
// riscv_state_pkg
// Core-wide state types. Holds the PMP arbiter source encoding and the
// default instruction-starvation limit.
// ---------------------------------------------------------------------------
package riscv_state_pkg;

   typedef enum logic {
      SRC_DAT = 1'b0,
      SRC_INS = 1'b1
   } pmp_arb_src_t;

   localparam int unsigned PMP_ARB_STARVE_MAX = 4;

endpackage

// File: rtl/riscv_pmp_arb_sel.sv
// ---------------------------------------------------------------------------
// riscv_pmp_arb_sel
// Grant selection for the shared PMP checker. Combinational grants from the
// request pair plus the fairness state held here.
//
// Build option: RISCV_PMP_ARB_RR_EN
//   undefined : data has priority; instruction wins once it has lost
//               STARVE_MAX consecutive cycles while requesting.
//   defined   : strict round-robin between the two requesters.
//
// Ports
//   clk_i, rst_ni          clock, synchronous active-low reset
//   ins_req_i, dat_req_i   requests (ins_req_i already masked by flush)
//   ins_gnt_o, dat_gnt_o   one-hot-or-zero grants
// ---------------------------------------------------------------------------
module riscv_pmp_arb_sel
   import riscv_state_pkg::*;
#(
   parameter int unsigned STARVE_MAX = PMP_ARB_STARVE_MAX
)(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic ins_req_i,
   input  logic dat_req_i,
   output logic ins_gnt_o,
   output logic dat_gnt_o
);

`ifdef RISCV_PMP_ARB_RR_EN

   // prio_q holds the requester that wins the next contested cycle, i.e. the
   // one that did not win the last grant. Resetting it to data makes data
   // win the first contested cycle after reset.
   pmp_arb_src_t prio_q, prio_d;

   always_comb begin
      ins_gnt_o = ins_req_i & (~dat_req_i | (prio_q == SRC_INS));
      dat_gnt_o = dat_req_i & ~ins_gnt_o;
      prio_d    = prio_q;
      if (ins_gnt_o)      prio_d = SRC_DAT;
      else if (dat_gnt_o) prio_d = SRC_INS;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) prio_q <= SRC_DAT;
      else         prio_q <= prio_d;
   end

`else

   logic [3:0] starve_q, starve_d;
   logic       starved;

   assign starved = (starve_q == 4'(STARVE_MAX));

   always_comb begin
      ins_gnt_o = ins_req_i & (~dat_req_i | starved);
      dat_gnt_o = dat_req_i & ~ins_gnt_o;
      starve_d  = '0;
      if (ins_req_i && dat_gnt_o)
         starve_d = starved ? starve_q : starve_q + 4'd1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) starve_q <= '0;
      else         starve_q <= starve_d;
   end

`endif

endmodule

// File: rtl/riscv_pmp_arb.sv
// ---------------------------------------------------------------------------
// riscv_pmp_arb
// Shares one PMP checker between instruction fetch and data access.
// Pipeline: grant (cycle N) -> check stage drives checker (N+1) ->
// registered per-requester result (N+2). One check accepted per cycle.
//
// Build option: RISCV_PMP_ARB_RR_EN selects round-robin arbitration
// (see riscv_pmp_arb_sel); default is data priority with starvation limit.
//
// Ports
//   clk_i, rst_ni                      clock, synchronous active-low reset
//   ins_req/adr/size_i, ins_gnt_o      instruction request side
//   ins_valid_o, ins_exception_o       instruction result
//   dat_req/adr/size/we_i, dat_gnt_o   data request side
//   dat_valid_o, dat_exception_o       data result
//   ins_flush_i                        kill in-flight instruction checks
//   chk_*_o / chk_exception_i          PMP checker interface
// ---------------------------------------------------------------------------
module riscv_pmp_arb
   import biu_constants_pkg::*;
   import riscv_state_pkg::*;
#(
   parameter int          XLEN       = 32,
   parameter int          PLEN       = (XLEN == 32 ? 34 : 56),
   parameter int unsigned STARVE_MAX = PMP_ARB_STARVE_MAX
)(
   input  logic            clk_i,
   input  logic            rst_ni,

   input  logic            ins_req_i,
   input  logic [PLEN-1:0] ins_adr_i,
   input  biu_size_t       ins_size_i,
   output logic            ins_gnt_o,
   output logic            ins_valid_o,
   output logic            ins_exception_o,

   input  logic            dat_req_i,
   input  logic [PLEN-1:0] dat_adr_i,
   input  biu_size_t       dat_size_i,
   input  logic            dat_we_i,
   output logic            dat_gnt_o,
   output logic            dat_valid_o,
   output logic            dat_exception_o,

   input  logic            ins_flush_i,

   output logic            chk_req_o,
   output logic            chk_instruction_o,
   output logic [PLEN-1:0] chk_adr_o,
   output biu_size_t       chk_size_o,
   output logic            chk_we_o,
   input  logic            chk_exception_i
);

   logic ins_gnt, dat_gnt;

   // Flush suppresses the instruction grant; data may still win that cycle.
   riscv_pmp_arb_sel #(
      .STARVE_MAX (STARVE_MAX)
   ) u_sel (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .ins_req_i (ins_req_i & ~ins_flush_i),
      .dat_req_i (dat_req_i),
      .ins_gnt_o (ins_gnt),
      .dat_gnt_o (dat_gnt)
   );

   assign ins_gnt_o = ins_gnt;
   assign dat_gnt_o = dat_gnt;

   // Stage 1: check
   logic            chk_req_q,  chk_req_d;
   pmp_arb_src_t    chk_src_q,  chk_src_d;
   logic [PLEN-1:0] chk_adr_q,  chk_adr_d;
   biu_size_t       chk_size_q, chk_size_d;
   logic            chk_we_q,   chk_we_d;

   always_comb begin
      chk_req_d  = ins_gnt | dat_gnt;
      chk_src_d  = SRC_DAT;
      chk_adr_d  = chk_adr_q;
      chk_size_d = chk_size_q;
      chk_we_d   = 1'b0;
      if (dat_gnt) begin
         chk_adr_d  = dat_adr_i;
         chk_size_d = dat_size_i;
         chk_we_d   = dat_we_i;
      end else if (ins_gnt) begin
         chk_src_d  = SRC_INS;
         chk_adr_d  = ins_adr_i;
         chk_size_d = ins_size_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         chk_req_q  <= 1'b0;
         chk_src_q  <= SRC_DAT;
         chk_adr_q  <= '0;
         chk_size_q <= BYTE;
         chk_we_q   <= 1'b0;
      end else begin
         chk_req_q  <= chk_req_d;
         chk_src_q  <= chk_src_d;
         chk_adr_q  <= chk_adr_d;
         chk_size_q <= chk_size_d;
         chk_we_q   <= chk_we_d;
      end
   end

   assign chk_req_o         = chk_req_q;
   assign chk_instruction_o = (chk_src_q == SRC_INS);
   assign chk_adr_o         = chk_adr_q;
   assign chk_size_o        = chk_size_q;
   assign chk_we_o          = chk_we_q;

   // Stage 2: result. A flush kills the instruction entry leaving stage 1,
   // which covers the flush-versus-capture collision.
   logic ins_valid_q, ins_valid_d, ins_exc_q, ins_exc_d;
   logic dat_valid_q, dat_valid_d, dat_exc_q, dat_exc_d;

   always_comb begin
      ins_valid_d = chk_req_q & (chk_src_q == SRC_INS) & ~ins_flush_i;
      dat_valid_d = chk_req_q & (chk_src_q == SRC_DAT);
      ins_exc_d   = ins_valid_d & chk_exception_i;
      dat_exc_d   = dat_valid_d & chk_exception_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ins_valid_q <= 1'b0;
         ins_exc_q   <= 1'b0;
         dat_valid_q <= 1'b0;
         dat_exc_q   <= 1'b0;
      end else begin
         ins_valid_q <= ins_valid_d;
         ins_exc_q   <= ins_exc_d;
         dat_valid_q <= dat_valid_d;
         dat_exc_q   <= dat_exc_d;
      end
   end

   assign ins_valid_o     = ins_valid_q;
   assign ins_exception_o = ins_exc_q;
   assign dat_valid_o     = dat_valid_q;
   assign dat_exception_o = dat_exc_q;

endmodule

// File: tb/tb_riscv_pmp_arb.sv
// ---------------------------------------------------------------------------
// tb_riscv_pmp_arb
// Self-checking bench for riscv_pmp_arb (default arbitration build).
// ---------------------------------------------------------------------------
module tb_riscv_pmp_arb;
   import biu_constants_pkg::*;

   localparam int          PLEN = 34;
   localparam int unsigned SM   = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            ins_req, dat_req, dat_we, ins_flush;
   logic [PLEN-1:0] ins_adr, dat_adr;
   biu_size_t       ins_size, dat_size;
   logic            ins_gnt, ins_valid, ins_exc;
   logic            dat_gnt, dat_valid, dat_exc;
   logic            chk_req, chk_ins, chk_we, chk_exc;
   logic [PLEN-1:0] chk_adr;
   biu_size_t       chk_size;

   int unsigned exc_mode;

   always #5 clk = ~clk;

   // Checker stand-in: 0 = never fault, 1 = always fault, 2 = fault on adr[12]
   assign chk_exc = (exc_mode == 0) ? 1'b0 : (exc_mode == 1) ? 1'b1 : chk_adr[12];

   riscv_pmp_arb #(
      .XLEN       (32),
      .STARVE_MAX (SM)
   ) dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .ins_req_i         (ins_req),
      .ins_adr_i         (ins_adr),
      .ins_size_i        (ins_size),
      .ins_gnt_o         (ins_gnt),
      .ins_valid_o       (ins_valid),
      .ins_exception_o   (ins_exc),
      .dat_req_i         (dat_req),
      .dat_adr_i         (dat_adr),
      .dat_size_i        (dat_size),
      .dat_we_i          (dat_we),
      .dat_gnt_o         (dat_gnt),
      .dat_valid_o       (dat_valid),
      .dat_exception_o   (dat_exc),
      .ins_flush_i       (ins_flush),
      .chk_req_o         (chk_req),
      .chk_instruction_o (chk_ins),
      .chk_adr_o         (chk_adr),
      .chk_size_o        (chk_size),
      .chk_we_o          (chk_we),
      .chk_exception_i   (chk_exc)
   );

   typedef struct {
      logic            ir;
      logic [PLEN-1:0] ia;
      biu_size_t       isz;
      logic            dr;
      logic [PLEN-1:0] da;
      biu_size_t       dsz;
      logic            dwe;
      logic            fl;
      logic            eig;
      logic            edg;
   } vec_t;

   typedef struct {
      int   due;
      logic ins;
      logic exc;
   } res_t;

   res_t sbq[$];

   int              checks = 0;
   int              passes = 0;
   int              cyc    = 0;
   int unsigned     cnt_m  = 0;
   logic            p_req  = 1'b0;
   logic            p_ins  = 1'b0;
   logic            p_we   = 1'b0;
   logic [PLEN-1:0] p_adr  = '0;
   biu_size_t       p_size = BYTE;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
   endtask

   function automatic logic exc_of(input logic [PLEN-1:0] a);
      return (exc_mode == 0) ? 1'b0 : (exc_mode == 1) ? 1'b1 : a[12];
   endfunction

   // Builds a vector whose expected grants come from the starvation model.
   function automatic vec_t mk(input logic ir, input logic [PLEN-1:0] ia, input logic dr,
                               input logic [PLEN-1:0] da, input logic dwe, input logic fl);
      vec_t v;
      v.ir = ir; v.ia = ia; v.isz = WORD;
      v.dr = dr; v.da = da; v.dsz = WORD; v.dwe = dwe; v.fl = fl;
      v.eig = ir & ~fl & (~dr | (cnt_m == SM));
      v.edg = dr & ~v.eig;
      return v;
   endfunction

   task automatic check_results();
      logic ev_i, ee_i, ev_d, ee_d;
      ev_i = 1'b0; ee_i = 1'b0; ev_d = 1'b0; ee_d = 1'b0;
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
         checks++;
         $display("FAIL sb_lost cycle %0d: result due %0d never matched", cyc, sbq[0].due);
         void'(sbq.pop_front());
      end
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
         if (sbq[0].ins) begin ev_i = 1'b1; ee_i = sbq[0].exc; end
         else            begin ev_d = 1'b1; ee_d = sbq[0].exc; end
         void'(sbq.pop_front());
      end
      check("ins_valid", ins_valid, ev_i);
      check("ins_exc",   ins_exc,   ee_i);
      check("dat_valid", dat_valid, ev_d);
      check("dat_exc",   dat_exc,   ee_d);
   endtask

   task automatic run_vec(input vec_t v);
      res_t keep[$];
      @(posedge clk); #1;
      rst_n    = 1'b1;
      ins_req  = v.ir; ins_adr = v.ia; ins_size = v.isz;
      dat_req  = v.dr; dat_adr = v.da; dat_size = v.dsz; dat_we = v.dwe;
      ins_flush = v.fl;
      @(negedge clk);
      check("ins_gnt", ins_gnt, v.eig);
      check("dat_gnt", dat_gnt, v.edg);
      check("chk_req", chk_req, p_req);
      check("chk_adr", chk_adr, p_adr);
      check("chk_size", chk_size, p_size);
      if (p_req) begin
         check("chk_instr", chk_ins, p_ins);
         check("chk_we", chk_we, p_we);
      end
      check_results();
      if (v.fl) begin
         foreach (sbq[k]) if (!(sbq[k].ins && sbq[k].due == cyc + 1)) keep.push_back(sbq[k]);
         sbq = keep;
      end
      if (v.edg) begin
         sbq.push_back('{cyc + 2, 1'b0, exc_of(v.da)});
         p_adr = v.da; p_size = v.dsz; p_ins = 1'b0; p_we = v.dwe;
      end else if (v.eig) begin
         sbq.push_back('{cyc + 2, 1'b1, exc_of(v.ia)});
         p_adr = v.ia; p_size = v.isz; p_ins = 1'b1; p_we = 1'b0;
      end
      p_req = v.eig | v.edg;
      if (v.ir && !v.fl && v.edg) cnt_m = (cnt_m == SM) ? cnt_m : cnt_m + 1;
      else                        cnt_m = 0;
      cyc++;
   endtask

   task automatic reset_cycle();
      @(posedge clk); #1;
      rst_n = 1'b0;
      ins_req = 1'b0; dat_req = 1'b0; ins_flush = 1'b0; dat_we = 1'b0;
      @(negedge clk);
      check("rst_ins_gnt", ins_gnt, 1'b0);
      check("rst_dat_gnt", dat_gnt, 1'b0);
      check_results();
      sbq.delete();
      cnt_m = 0; p_req = 1'b0; p_ins = 1'b0; p_we = 1'b0; p_adr = '0; p_size = BYTE;
      cyc++;
   endtask

   vec_t vt[12];
   vec_t idle;

   initial begin
      rst_n = 1'b0; ins_req = 1'b0; dat_req = 1'b0; dat_we = 1'b0; ins_flush = 1'b0;
      ins_adr = '0; dat_adr = '0; ins_size = BYTE; dat_size = BYTE;
      exc_mode = 1;

      idle  = '{1'b0, '0, BYTE, 1'b0, '0, BYTE, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[0]  = '{1'b0, 34'h0,    BYTE, 1'b1, 34'h1000, WORD,  1'b1, 1'b0, 1'b0, 1'b1};
      vt[1]  = idle;
      vt[2]  = idle;
      vt[3]  = '{1'b1, 34'h2000, WORD, 1'b0, 34'h0,    BYTE,  1'b0, 1'b0, 1'b1, 1'b0};
      vt[4]  = '{1'b1, 34'h2004, WORD, 1'b1, 34'h3000, HWORD, 1'b0, 1'b0, 1'b0, 1'b1};
      vt[5]  = '{1'b1, 34'h2008, WORD, 1'b0, 34'h0,    BYTE,  1'b0, 1'b0, 1'b1, 1'b0};
      vt[6]  = '{1'b1, 34'h200C, WORD, 1'b1, 34'h3004, BYTE,  1'b1, 1'b1, 1'b0, 1'b1};
      vt[7]  = idle;
      vt[8]  = idle;
      vt[9]  = '{1'b1, 34'h2010, WORD, 1'b0, 34'h0,    BYTE,  1'b0, 1'b1, 1'b0, 1'b0};
      vt[10] = idle;
      vt[11] = idle;

      reset_cycle();
      reset_cycle();

      for (int i = 0; i < 12; i++) run_vec(vt[i]);

      // Continuous contention: D,D,D,D,I repeating, fault on adr[12]
      exc_mode = 2;
      for (int i = 0; i < 15; i++)
         run_vec(mk(1'b1, 34'h4000 + (34'(i) << 12), 1'b1, 34'h8000 + (34'(i + 1) << 12),
                    1'(i % 2), 1'b0));
      run_vec(idle);
      run_vec(idle);

      // Back-to-back alternating checks
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) run_vec(mk(1'b0, '0, 1'b1, 34'h20000 + (34'(i / 2) << 12), 1'b0, 1'b0));
         else            run_vec(mk(1'b1, 34'h30000 + (34'(i / 2) << 12), 1'b0, '0, 1'b0, 1'b0));
      end
      run_vec(idle);
      run_vec(idle);

      // Reset while checks are in flight and the starvation count is non-zero
      for (int i = 0; i < 3; i++)
         run_vec(mk(1'b1, 34'h5000 + (34'(i) << 12), 1'b1, 34'h9000 + (34'(i) << 12), 1'b1, 1'b0));
      reset_cycle();
      run_vec(idle);
      check("post_rst_size", chk_size, BYTE);
      check("post_rst_we", chk_we, 1'b0);
      check("post_rst_ins", chk_ins, 1'b0);
      for (int i = 0; i < 6; i++)
         run_vec(mk(1'b1, 34'h6000 + (34'(i) << 12), 1'b1, 34'hA000 + (34'(i) << 12), 1'b0, 1'b0));
      run_vec(idle);
      run_vec(idle);
      run_vec(idle);

      check("sb_empty", 64'(sbq.size()), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
